// File: rtl/kmap_pkg.sv
// Shared types and limits for the K-map sweep controller.
package kmap_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SAMPLE,
        DONE
    } state_t;

    localparam int MAX_SETTLE = 15;
    localparam int CNT_W      = $clog2(MAX_SETTLE + 1);

endpackage

// File: rtl/kmap_sweep_ctrl_settle_cnt.sv
// Loadable down-counter; elapsed is high once the loaded hold time has run out.
module settle_cnt
    import kmap_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             elapsed
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign elapsed = (cnt == '0);

endmodule

// File: rtl/kmap_sweep_ctrl.sv
// Drives an N_IN-input combinational block through every code and records its truth table.
// Optional golden-table compare is enabled by defining KMAP_CHECK_EN.
module kmap_sweep_ctrl
    import kmap_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [N_IN-1:0]      vec_out,
    input  logic                 f_in,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out,
`ifdef KMAP_CHECK_EN
    input  logic [2**N_IN-1:0]   golden,
    output logic                 mismatch,
    output logic [N_IN-1:0]      first_fail,
`endif
    output logic [N_IN:0]        ones_cnt
);

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]  LAST_CODE = '1;

    state_t state;
    logic   cnt_load;
    logic   settled;

`ifdef KMAP_CHECK_EN
    logic [2**N_IN-1:0] golden_q;
`endif

    // The hold counter restarts for every code, both on an accepted start and on each advance.
    assign cnt_load = ((state == IDLE) && start) ||
                      ((state == SAMPLE) && (vec_out != LAST_CODE));

    settle_cnt u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (SETTLE_LD),
        .en       (state == WAIT),
        .elapsed  (settled)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            vec_out   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            table_out <= '0;
            ones_cnt  <= '0;
`ifdef KMAP_CHECK_EN
            golden_q   <= '0;
            mismatch   <= 1'b0;
            first_fail <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        vec_out   <= '0;
                        table_out <= '0;
                        ones_cnt  <= '0;
                        busy      <= 1'b1;
                        state     <= WAIT;
`ifdef KMAP_CHECK_EN
                        golden_q   <= golden;
                        mismatch   <= 1'b0;
                        first_fail <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (settled) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    table_out[vec_out] <= f_in;
                    ones_cnt           <= ones_cnt + (N_IN + 1)'(f_in);
`ifdef KMAP_CHECK_EN
                    // Only the first miss of a sweep is reported.
                    if ((f_in != golden_q[vec_out]) && !mismatch) begin
                        mismatch   <= 1'b1;
                        first_fail <= vec_out;
                    end
`endif
                    if (vec_out == LAST_CODE) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        vec_out <= vec_out + 1'b1;
                        state   <= WAIT;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
